// File: rtl/alu_lockstep_pkg.sv
// Shared definitions for the dual-lane lockstep ALU comparator.
// Op encodings, the op typedef and default widths.
package alu_lockstep_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

endpackage

// File: rtl/alu_lockstep_cmp_if.sv
// Per-lane bundle: operands/select in, stage-1 result and carry out.
interface alu_lockstep_cmp_if
  import alu_lockstep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_e              sel;
  logic [WIDTH-1:0] res;
  logic             carry;

  modport master (output valid, a, b, sel, input res, carry);
  modport slave  (input valid, a, b, sel, output res, carry);
endinterface

// File: rtl/alu_lane.sv
// One ALU lane: combinational op followed by the stage-1 result register.
// The data registers hold their value on cycles without a valid input.
module alu_lane
  import alu_lockstep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_lockstep_cmp_if.slave  lane
);

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [WIDTH-1:0] res_d, res_q;
  logic             carry_d, carry_q;

  assign sum_w = {1'b0, lane.a} + {1'b0, lane.b};
  // Bit WIDTH of the extended difference is the unsigned borrow.
  assign dif_w = {1'b0, lane.a} - {1'b0, lane.b};

  always_comb begin
    // NOTE: default every comb output first so no path infers a latch.
    res_d   = res_q;
    carry_d = carry_q;
    if (lane.valid) begin
      unique case (lane.sel)
        OP_ADD: begin res_d = sum_w[WIDTH-1:0]; carry_d = sum_w[WIDTH]; end
        OP_SUB: begin res_d = dif_w[WIDTH-1:0]; carry_d = dif_w[WIDTH]; end
        OP_AND: begin res_d = lane.a & lane.b;  carry_d = 1'b0;         end
        OP_XOR: begin res_d = lane.a ^ lane.b;  carry_d = 1'b0;         end
        default: begin res_d = '0;              carry_d = 1'b0;         end
      endcase
    end
  end

  // NOTE: data registers are reset too, so reset leaves no stale result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  assign lane.res   = res_q;
  assign lane.carry = carry_q;

endmodule

// File: rtl/alu_lockstep_cmp.sv
// Two-lane lockstep ALU with a 2-stage pipeline, result compare, sticky error
// and saturating mismatch counter. Define ALU_LOCKSTEP_CAPTURE_EN for first-mismatch capture.
module alu_lockstep_cmp
  import alu_lockstep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               in_valid_i,
  input  logic [WIDTH-1:0]   a0_i,
  input  logic [WIDTH-1:0]   b0_i,
  input  logic [WIDTH-1:0]   a1_i,
  input  logic [WIDTH-1:0]   b1_i,
  input  logic [1:0]         sel0_i,
  input  logic [1:0]         sel1_i,
  input  logic               clr_i,
  output logic               out_valid_o,
  output logic [WIDTH-1:0]   alu_out0_o,
  output logic [WIDTH-1:0]   alu_out1_o,
  output logic               carry0_o,
  output logic               carry1_o,
  output logic [WIDTH-1:0]   diff_o,
  output logic               carry_diff_o,
  output logic               mismatch_o,
  output logic               err_sticky_o,
`ifdef ALU_LOCKSTEP_CAPTURE_EN
  output logic               cap_valid_o,
  output logic [4*WIDTH+3:0] cap_o,
`endif
  output logic [CNT_W-1:0]   mis_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  alu_lockstep_cmp_if #(.WIDTH(WIDTH)) lane0 ();
  alu_lockstep_cmp_if #(.WIDTH(WIDTH)) lane1 ();

  assign lane0.valid = in_valid_i;
  assign lane0.a     = a0_i;
  assign lane0.b     = b0_i;
  assign lane0.sel   = op_e'(sel0_i);
  assign lane1.valid = in_valid_i;
  assign lane1.a     = a1_i;
  assign lane1.b     = b1_i;
  assign lane1.sel   = op_e'(sel1_i);

  alu_lane #(.WIDTH(WIDTH)) u_lane0 (.clk(wb_clk_i), .rst_n(wb_rst_ni), .lane(lane0.slave));
  alu_lane #(.WIDTH(WIDTH)) u_lane1 (.clk(wb_clk_i), .rst_n(wb_rst_ni), .lane(lane1.slave));

  logic             s1_valid_d, s1_valid_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out0_d, out0_q, out1_d, out1_q, diff_d, diff_q;
  logic             c0_d, c0_q, c1_d, c1_q, cdiff_d, cdiff_q;
  logic             mismatch_d, mismatch_q;
  logic             err_sticky_d, err_sticky_q;
  logic [CNT_W-1:0] cnt_base, mis_cnt_d, mis_cnt_q;

  always_comb begin
    s1_valid_d   = in_valid_i;
    out_valid_d  = s1_valid_q;
    out0_d       = lane0.res;
    out1_d       = lane1.res;
    c0_d         = lane0.carry;
    c1_d         = lane1.carry;
    diff_d       = lane0.res ^ lane1.res;
    cdiff_d      = lane0.carry ^ lane1.carry;
    mismatch_d   = s1_valid_q & ((|diff_d) | cdiff_d);
    // Clear is applied before the same-cycle mismatch is counted.
    cnt_base     = clr_i ? '0 : mis_cnt_q;
    mis_cnt_d    = (mismatch_q && cnt_base != CNT_MAX) ? cnt_base + CNT_W'(1) : cnt_base;
    err_sticky_d = (~clr_i & err_sticky_q) | mismatch_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out0_q       <= '0;
      out1_q       <= '0;
      c0_q         <= 1'b0;
      c1_q         <= 1'b0;
      diff_q       <= '0;
      cdiff_q      <= 1'b0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      mis_cnt_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out0_q       <= out0_d;
      out1_q       <= out1_d;
      c0_q         <= c0_d;
      c1_q         <= c1_d;
      diff_q       <= diff_d;
      cdiff_q      <= cdiff_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign alu_out0_o   = out0_q;
  assign alu_out1_o   = out1_q;
  assign carry0_o     = c0_q;
  assign carry1_o     = c1_q;
  assign diff_o       = diff_q;
  assign carry_diff_o = cdiff_q;
  assign mismatch_o   = mismatch_q;
  assign err_sticky_o = err_sticky_q;
  assign mis_cnt_o    = mis_cnt_q;

`ifdef ALU_LOCKSTEP_CAPTURE_EN
  // Operands travel alongside the pipeline so stage 2 sees its own inputs.
  logic [4*WIDTH+3:0] op1_d, op1_q, op2_d, op2_q, cap_d, cap_q;
  logic               cap_valid_d, cap_valid_q;

  always_comb begin
    op1_d       = in_valid_i ? {sel0_i, a0_i, b0_i, sel1_i, a1_i, b1_i} : op1_q;
    op2_d       = op1_q;
    cap_valid_d = ~clr_i & cap_valid_q;
    cap_d       = clr_i ? '0 : cap_q;
    if (mismatch_q && !cap_valid_d) begin
      cap_valid_d = 1'b1;
      cap_d       = op2_q;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      op1_q       <= '0;
      op2_q       <= '0;
      cap_q       <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      cap_q       <= cap_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign cap_valid_o = cap_valid_q;
  assign cap_o       = cap_q;
`endif

endmodule

// File: tb/tb_alu_lockstep_cmp.sv
// Directed, table-driven bench for alu_lockstep_cmp at WIDTH=4, CNT_W=8.
// Capture checks are built when ALU_LOCKSTEP_CAPTURE_EN is defined.
module tb_alu_lockstep_cmp;
  import alu_lockstep_pkg::*;

  localparam int W = 4;
  localparam int CW = 8;

  typedef struct {
    logic [1:0]   s0;
    logic [W-1:0] a0, b0;
    logic [1:0]   s1;
    logic [W-1:0] a1, b1;
    logic [W-1:0] r0;
    logic         c0;
    logic [W-1:0] r1;
    logic         c1;
    logic         mis;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          out_valid, diff_cd, mismatch, sticky;
  logic [W-1:0]  diff;
  logic [CW-1:0] cnt;
`ifdef ALU_LOCKSTEP_CAPTURE_EN
  logic          cap_valid;
  logic [4*W+3:0] cap;
`endif

  alu_lockstep_cmp_if #(.WIDTH(W)) l0 ();
  alu_lockstep_cmp_if #(.WIDTH(W)) l1 ();

  always #5 clk = ~clk;

  alu_lockstep_cmp #(.WIDTH(W), .CNT_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .in_valid_i(l0.valid),
    .a0_i(l0.a), .b0_i(l0.b), .a1_i(l1.a), .b1_i(l1.b),
    .sel0_i(l0.sel), .sel1_i(l1.sel), .clr_i(clr),
    .out_valid_o(out_valid), .alu_out0_o(l0.res), .alu_out1_o(l1.res),
    .carry0_o(l0.carry), .carry1_o(l1.carry), .diff_o(diff),
    .carry_diff_o(diff_cd), .mismatch_o(mismatch), .err_sticky_o(sticky),
`ifdef ALU_LOCKSTEP_CAPTURE_EN
    .cap_valid_o(cap_valid), .cap_o(cap),
`endif
    .mis_cnt_o(cnt)
  );

  int n_checks = 0;
  int n_fail = 0;
  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] s0, input int a0, input int b0,
                              input logic [1:0] s1, input int a1, input int b1,
                              input int r0, input bit c0, input int r1, input bit c1, input bit mis);
    vec_t v;
    v.s0 = s0; v.a0 = W'(a0); v.b0 = W'(b0);
    v.s1 = s1; v.a1 = W'(a1); v.b1 = W'(b1);
    v.r0 = W'(r0); v.c0 = c0; v.r1 = W'(r1); v.c1 = c1; v.mis = mis;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic valid);
    l0.valid = valid; l1.valid = valid;
    l0.sel = op_e'(v.s0); l0.a = v.a0; l0.b = v.b0;
    l1.sel = op_e'(v.s1); l1.a = v.a1; l1.b = v.b1;
  endtask

  task automatic idle();
    l0.valid = 1'b0; l1.valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".out0"}, 32'(l0.res), 32'(v.r0));
    check({tag, ".carry0"}, 32'(l0.carry), 32'(v.c0));
    check({tag, ".out1"}, 32'(l1.res), 32'(v.r1));
    check({tag, ".carry1"}, 32'(l1.carry), 32'(v.c1));
    check({tag, ".diff"}, 32'(diff), 32'(v.r0 ^ v.r1));
    check({tag, ".carry_diff"}, 32'(diff_cd), 32'(v.c0 ^ v.c1));
    check({tag, ".mismatch"}, 32'(mismatch), 32'(v.mis));
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    bit saw;
    vt[0] = mk(2'b00, 9, 9,   2'b00, 9, 9,   2, 1, 2, 1, 0);   // ADD wrap with carry
    vt[1] = mk(2'b01, 3, 5,   2'b01, 5, 3,   14, 1, 2, 0, 1);  // SUB borrow vs no borrow
    vt[2] = mk(2'b10, 12, 10, 2'b10, 12, 10, 8, 0, 8, 0, 0);   // AND
    vt[3] = mk(2'b11, 12, 10, 2'b11, 12, 10, 6, 0, 6, 0, 0);   // XOR
    vt[4] = mk(2'b00, 15, 1,  2'b00, 7, 8,   0, 1, 15, 0, 1);  // ADD overflow vs none
    vt[5] = mk(2'b01, 5, 5,   2'b01, 5, 5,   0, 0, 0, 0, 0);   // SUB equal operands
    vt[6] = mk(2'b10, 15, 3,  2'b11, 15, 3,  3, 0, 12, 0, 1);  // AND vs XOR
    vt[7] = mk(2'b01, 0, 1,   2'b01, 0, 1,   15, 1, 15, 1, 0); // SUB underflow

    idle(); drive(vt[0], 1'b0);
    #12;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.outputs", {l0.res, l1.res, diff, 1'b0, l0.carry, l1.carry, diff_cd}, 0);
    check("rst.mismatch", 32'(mismatch), 0);
    check("rst.sticky", 32'(sticky), 0);
    check("rst.cnt", 32'(cnt), 0);
    @(negedge clk); rst_n = 1'b1;

    // One vector at a time: latency, data, then counter and sticky.
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(vt[i], 1'b1);
      @(negedge clk); idle();
      check($sformatf("single%0d.lat1", i), 32'(out_valid), 0);
      @(negedge clk);
      check_out($sformatf("single%0d", i), vt[i]);
      if (vt[i].mis) exp_cnt++;
      @(negedge clk);
      check($sformatf("single%0d.vld_drop", i), 32'(out_valid), 0);
      check($sformatf("single%0d.mis_drop", i), 32'(mismatch), 0);
      check($sformatf("single%0d.cnt", i), 32'(cnt), 32'(exp_cnt));
      check($sformatf("single%0d.sticky", i), 32'(sticky), 32'(exp_cnt > 0));
    end

    // Back-to-back: one result per cycle, none dropped.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) check_out($sformatf("stream%0d", i - 2), vt[i - 2]);
      if (i < 8) drive(vt[i], 1'b1); else idle();
    end
    @(negedge clk);
    check("stream.cnt", 32'(cnt), 32'(exp_cnt + 3));
    check("stream.idle_valid", 32'(out_valid), 0);

    // Saturation: 300 consecutive mismatches.
    pulse_clr();
    check("sat.clr_cnt", 32'(cnt), 0);
    check("sat.clr_sticky", 32'(sticky), 0);
    for (int i = 0; i < 300; i++) begin
      drive(vt[1], 1'b1);
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);
    check("sat.cnt", 32'(cnt), 255);
    check("sat.sticky", 32'(sticky), 1);

    // Clear and mismatch on the same cycle, with 7 counted beforehand.
    pulse_clr();
    for (int i = 0; i < 7; i++) begin
      drive(vt[4], 1'b1);
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);
    check("simul.pre_cnt", 32'(cnt), 7);
    drive(vt[6], 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    check("simul.mismatch", 32'(mismatch), 1);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("simul.cnt", 32'(cnt), 1);
    check("simul.sticky", 32'(sticky), 1);
    pulse_clr();
    check("clr_only.cnt", 32'(cnt), 0);
    check("clr_only.sticky", 32'(sticky), 0);

`ifdef ALU_LOCKSTEP_CAPTURE_EN
    check("cap.clear_valid", 32'(cap_valid), 0);
    @(negedge clk); drive(vt[1], 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    check("cap.before_set", 32'(cap_valid), 0);
    @(negedge clk);
    check("cap.valid_with_sticky", {31'd0, cap_valid}, {31'd0, sticky});
    drive(vt[6], 1'b1);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    check("cap.cnt_two", 32'(cnt), 2);
    check("cap.valid", 32'(cap_valid), 1);
    check("cap.first_ops", 32'(cap), 32'({2'b01, 4'd3, 4'd5, 2'b01, 4'd5, 4'd3}));
    pulse_clr();
    check("cap.clr_valid", 32'(cap_valid), 0);
    check("cap.clr_data", 32'(cap), 0);
`endif

    // Reset while operations are in flight.
    @(negedge clk); drive(vt[1], 1'b1);
    @(negedge clk); drive(vt[0], 1'b1);
    @(posedge clk); #2;
    idle();
    rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", 32'(out_valid), 0);
    check("mid_rst.data", {l0.res, l1.res, diff, 1'b0, l0.carry, l1.carry, diff_cd}, 0);
    check("mid_rst.flags", {mismatch, sticky}, 0);
    check("mid_rst.cnt", 32'(cnt), 0);
    @(negedge clk); rst_n = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("mid_rst.no_valid_after", 32'(saw), 0);

    // First valid after release appears two cycles later.
    drive(vt[2], 1'b1);
    @(negedge clk); idle();
    check("post_rst.lat1", 32'(out_valid), 0);
    @(negedge clk);
    check_out("post_rst", vt[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
